// File: rtl/mac_pkg.sv
// Shared constants, FSM state encoding and byte-wide CRC-32 step for the Ethernet TX framer.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } tx_state_t;

  // Reflected CRC-32, LSB of the byte enters first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_tx_framer.sv
// Ethernet TX framer: preamble/SFD insertion, zero padding, FCS append, IFG enforcement,
// underrun/oversize abort. All GMII outputs are registered and advance only on tx_ce.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int CRC_APPEND   = 1
) (
  input  logic        mac_tx_clk,
  input  logic        rst_n,
  input  logic        tx_ce,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        frame_done,
  output logic        underrun,
  output logic        oversize,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0]  PRE_L   = 4'(PREAMBLE_LEN);
  localparam logic [15:0] IFG_L   = 16'(IFG_BYTES);
  localparam logic [10:0] MIN_P   = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P   = 11'(MAX_PAYLOAD);
  localparam bit          USE_FCS = (CRC_APPEND != 0);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  tx_state_t   state, state_n;
  logic [31:0] crc, crc_n;
  logic [10:0] pay_cnt, pay_cnt_n, cnt_inc;
  logic [3:0]  pre_cnt, pre_cnt_n;
  logic [15:0] ifg_cnt, ifg_cnt_n;
  logic [1:0]  fcs_idx, fcs_idx_n;
  logic [7:0]  txd_n;
  logic        tx_en_n, tx_er_n, done_n, und_n, ovs_n, to_tail;
  logic [15:0] frame_cnt_n;

  assign cnt_inc = sat_inc11(pay_cnt);

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    pay_cnt_n   = pay_cnt;
    pre_cnt_n   = pre_cnt;
    ifg_cnt_n   = ifg_cnt;
    fcs_idx_n   = fcs_idx;
    txd_n       = gmii_txd;
    tx_en_n     = gmii_tx_en;
    tx_er_n     = gmii_tx_er;
    frame_cnt_n = frame_cnt;
    done_n      = 1'b0;
    und_n       = 1'b0;
    ovs_n       = 1'b0;
    s_ready     = 1'b0;
    to_tail     = 1'b0;
    if (tx_ce) begin
      txd_n   = 8'h00;
      tx_en_n = 1'b0;
      tx_er_n = 1'b0;
      case (state)
        ST_IDLE: begin
          // The SOF byte itself is held back until the preamble has gone out.
          s_ready = s_valid & ~s_sof;
          if (s_valid && s_sof) begin
            txd_n     = PREAMBLE_BYTE;
            tx_en_n   = 1'b1;
            pre_cnt_n = 4'd1;
            crc_n     = CRC_INIT;
            pay_cnt_n = 11'd0;
            state_n   = (PRE_L <= 4'd1) ? ST_SFD : ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          txd_n     = PREAMBLE_BYTE;
          tx_en_n   = 1'b1;
          pre_cnt_n = pre_cnt + 4'd1;
          if (pre_cnt + 4'd1 >= PRE_L) state_n = ST_SFD;
        end
        ST_SFD: begin
          txd_n   = SFD_BYTE;
          tx_en_n = 1'b1;
          state_n = ST_DATA;
        end
        ST_DATA: begin
          s_ready = 1'b1;
          tx_en_n = 1'b1;
          if (!s_valid) begin
            tx_er_n = 1'b1;
            und_n   = 1'b1;
            state_n = ST_DRAIN;
          end else begin
            txd_n     = s_data;
            pay_cnt_n = cnt_inc;
            if (cnt_inc > MAX_P) begin
              tx_er_n   = 1'b1;
              ovs_n     = 1'b1;
              ifg_cnt_n = 16'd0;
              state_n   = s_eof ? ST_IFG : ST_DRAIN;
            end else begin
              crc_n = crc32_d8(crc, s_data);
              if (s_eof) begin
                if (cnt_inc < MIN_P) state_n = ST_PAD;
                else                 to_tail = 1'b1;
              end
            end
          end
        end
        ST_PAD: begin
          tx_en_n   = 1'b1;
          crc_n     = crc32_d8(crc, 8'h00);
          pay_cnt_n = cnt_inc;
          if (cnt_inc >= MIN_P) to_tail = 1'b1;
        end
        ST_FCS: begin
          txd_n     = 8'(~crc >> {fcs_idx, 3'b000});
          tx_en_n   = 1'b1;
          fcs_idx_n = fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state_n     = ST_IFG;
            ifg_cnt_n   = 16'd0;
            done_n      = 1'b1;
            frame_cnt_n = frame_cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          s_ready = 1'b1;
          if (s_valid && s_eof) begin
            state_n   = ST_IFG;
            ifg_cnt_n = 16'd0;
          end
        end
        ST_IFG: begin
          ifg_cnt_n = ifg_cnt + 16'd1;
          if (ifg_cnt + 16'd1 >= IFG_L) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
      // Payload (and any padding) finished: append FCS or close the frame directly.
      if (to_tail) begin
        if (USE_FCS) begin
          state_n   = ST_FCS;
          fcs_idx_n = 2'd0;
        end else begin
          state_n     = ST_IFG;
          ifg_cnt_n   = 16'd0;
          done_n      = 1'b1;
          frame_cnt_n = frame_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge mac_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      crc        <= CRC_INIT;
      pay_cnt    <= 11'd0;
      pre_cnt    <= 4'd0;
      ifg_cnt    <= 16'd0;
      fcs_idx    <= 2'd0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      oversize   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state      <= state_n;
      crc        <= crc_n;
      pay_cnt    <= pay_cnt_n;
      pre_cnt    <= pre_cnt_n;
      ifg_cnt    <= ifg_cnt_n;
      fcs_idx    <= fcs_idx_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= tx_en_n;
      gmii_tx_er <= tx_er_n;
      frame_done <= done_n;
      underrun   <= und_n;
      oversize   <= ovs_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: expected GMII bytes queued at stimulus time, popped per output byte.
module tb_mac_tx_framer;

  logic        mac_tx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_ce = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0;
  logic        s_ready, gmii_tx_en, gmii_tx_er, frame_done, underrun, oversize;
  logic [7:0]  gmii_txd;
  logic [15:0] frame_cnt;
  logic        np_ready, np_en, np_er, np_done, np_und, np_ovs;
  logic [7:0]  np_txd;
  logic [15:0] np_cnt;

  mac_tx_framer dut (
    .mac_tx_clk(mac_tx_clk), .rst_n(rst_n), .tx_ce(tx_ce),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eof(s_eof), .s_ready(s_ready),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .frame_done(frame_done), .underrun(underrun), .oversize(oversize), .frame_cnt(frame_cnt)
  );

  mac_tx_framer #(.MIN_PAYLOAD(0)) dut_np (
    .mac_tx_clk(mac_tx_clk), .rst_n(rst_n), .tx_ce(tx_ce),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eof(s_eof), .s_ready(np_ready),
    .gmii_txd(np_txd), .gmii_tx_en(np_en), .gmii_tx_er(np_er),
    .frame_done(np_done), .underrun(np_und), .oversize(np_ovs), .frame_cnt(np_cnt)
  );

  always #5 mac_tx_clk = ~mac_tx_clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] np_q[$];
  logic [7:0] pl[$];
  int  ce_div = 1;
  bit  mon_en = 1'b0, cap_np = 1'b0, hold_en = 1'b0;
  int  done_pulses = 0, und_pulses = 0, ovs_pulses = 0;
  int  gap = 0, last_gap = 0, hold_viol = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_bit(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Receive-side check over everything after preamble+SFD, reported in normal bit order.
  function automatic logic [31:0] residue_of(input int start);
    logic [31:0] c, r;
    c = 32'hFFFFFFFF;
    for (int k = start; k < rx_q.size(); k++) c = crc_bit(c, rx_q[k]);
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  // Byte-strobe generator.
  initial begin
    int ce_cnt = 0;
    forever begin
      @(posedge mac_tx_clk);
      #1;
      if (ce_div <= 1) tx_ce = 1'b1;
      else begin
        ce_cnt = (ce_cnt + 1) % ce_div;
        tx_ce  = (ce_cnt == 0);
      end
    end
  end

  // Output monitor: one slot per clock edge that had tx_ce high.
  initial begin
    bit ce_seen = 1'b0, slot;
    logic [7:0] prev_txd = 8'h00;
    logic prev_en = 1'b0;
    forever begin
      @(negedge mac_tx_clk);
      slot    = ce_seen;
      ce_seen = tx_ce && rst_n;
      if (rst_n) begin
        if (frame_done) done_pulses++;
        if (underrun)   und_pulses++;
        if (oversize)   ovs_pulses++;
        if (hold_en && !slot && (gmii_txd !== prev_txd || gmii_tx_en !== prev_en)) hold_viol++;
        if (slot && cap_np && np_en) np_q.push_back(np_txd);
        if (slot) begin
          if (gmii_tx_en) begin
            if (gap > 0) last_gap = gap;
            gap = 0;
            rx_q.push_back(gmii_txd);
            if (mon_en) begin
              if (exp_q.size() == 0) check_eq("unexpected_byte", {23'h0, gmii_tx_er, gmii_txd}, 32'h1FF);
              else check_eq("tx_byte", {23'h0, gmii_tx_er, gmii_txd}, {23'h0, exp_q.pop_front()});
            end
          end else gap++;
        end
      end
      prev_txd = gmii_txd;
      prev_en  = gmii_tx_en;
    end
  end

  // mode 0: good frame, 1: underrun after cut bytes, 2: oversize.
  task automatic push_frame(input int mode, input int cut);
    logic [31:0] c, f;
    for (int k = 0; k < 7; k++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    if (mode == 0) begin
      c = 32'hFFFFFFFF;
      for (int k = 0; k < pl.size(); k++) begin
        exp_q.push_back({1'b0, pl[k]});
        c = crc_bit(c, pl[k]);
      end
      for (int k = pl.size(); k < 60; k++) begin
        exp_q.push_back(9'h000);
        c = crc_bit(c, 8'h00);
      end
      f = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
    end else if (mode == 1) begin
      for (int k = 0; k < cut; k++) exp_q.push_back({1'b0, pl[k]});
      exp_q.push_back(9'h100);
    end else begin
      for (int k = 0; k < 1514; k++) exp_q.push_back({1'b0, pl[k]});
      exp_q.push_back({1'b1, pl[1514]});
    end
  endtask

  task automatic drive(input int stall_after, output int accepted);
    bit acc;
    int budget;
    accepted = 0;
    for (int i = 0; i < pl.size(); i++) begin
      s_data  = pl[i];
      s_sof   = (i == 0);
      s_eof   = (i == pl.size() - 1);
      s_valid = 1'b1;
      if (stall_after > 0 && i == stall_after) begin
        s_valid = 1'b0;
        budget  = 0;
        do begin
          @(negedge mac_tx_clk);
          budget++;
        end while (!tx_ce && budget < 100);
        @(posedge mac_tx_clk);
        #2;
        s_valid = 1'b1;
      end
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 3000) begin
        @(negedge mac_tx_clk);
        acc = s_ready;
        @(posedge mac_tx_clk);
        #2;
        budget++;
      end
      if (!acc) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        return;
      end
      accepted++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge mac_tx_clk);
      n++;
    end while ((exp_q.size() != 0 || gmii_tx_en) && n < budget);
    if (exp_q.size() != 0 || gmii_tx_en) begin
      check_eq("idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int acc, und0, ovs0, done0, n;
    logic [7:0] np_ref [21];

    repeat (3) @(posedge mac_tx_clk);
    @(negedge mac_tx_clk);
    check_eq("rst_tx_en", gmii_tx_en, 0);
    check_eq("rst_txd", gmii_txd, 0);
    check_eq("rst_tx_er", gmii_tx_er, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_pulses", {frame_done, underrun, oversize}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge mac_tx_clk);
    #2;

    // Known-answer frame on the unpadded instance, padded frame on the default one.
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    cap_np = 1'b1;
    push_frame(0, 0);
    drive(0, acc);
    wait_idle(2000);
    cap_np = 1'b0;
    for (int k = 0; k < 7; k++) np_ref[k] = 8'h55;
    np_ref[7] = 8'hD5;
    for (int k = 0; k < 9; k++) np_ref[8+k] = 8'h31 + 8'(k);
    np_ref[17] = 8'h26; np_ref[18] = 8'h39; np_ref[19] = 8'hF4; np_ref[20] = 8'hCB;
    check_eq("np_len", np_q.size(), 21);
    for (int k = 0; k < 21; k++)
      check_eq("np_byte", (k < np_q.size()) ? {24'h0, np_q[k]} : 32'hFFFF, {24'h0, np_ref[k]});
    check_eq("np_frame_cnt", np_cnt, 1);
    check_eq("t1_frame_cnt", frame_cnt, 1);
    check_eq("t1_done_pulses", done_pulses, 1);

    // Short frame padded to 60 bytes; receiver residue.
    pl.delete();
    for (int k = 0; k < 14; k++) pl.push_back(8'(k * 7 + 3));
    rx_q.delete();
    push_frame(0, 0);
    drive(0, acc);
    wait_idle(2000);
    check_eq("t2_len", rx_q.size(), 72);
    check_eq("t2_residue", residue_of(8), 32'hC704DD7B);
    check_eq("t2_frame_cnt", frame_cnt, 2);

    // Underrun after 20 bytes, then a good frame right behind it.
    und0 = und_pulses;
    pl.delete();
    for (int k = 0; k < 30; k++) pl.push_back(8'($urandom_range(0, 255)));
    push_frame(1, 20);
    drive(20, acc);
    check_eq("t3_frame_cnt_abort", frame_cnt, 2);
    pl.delete();
    for (int k = 0; k < 64; k++) pl.push_back(8'($urandom_range(0, 255)));
    push_frame(0, 0);
    drive(0, acc);
    wait_idle(2000);
    check_eq("t3_und_pulses", und_pulses - und0, 1);
    check_eq("t3_gap", last_gap, 22);
    check_eq("t3_frame_cnt", frame_cnt, 3);

    // Oversize: byte 1515 flagged, the rest drained.
    ovs0 = ovs_pulses;
    pl.delete();
    for (int k = 0; k < 1600; k++) pl.push_back(8'($urandom_range(0, 255)));
    push_frame(2, 0);
    drive(0, acc);
    wait_idle(2000);
    check_eq("t4_accepted", acc, 1600);
    check_eq("t4_ovs_pulses", ovs_pulses - ovs0, 1);
    check_eq("t4_frame_cnt", frame_cnt, 3);

    // 1-in-10 strobe, back-to-back frames.
    ce_div  = 10;
    repeat (12) @(posedge mac_tx_clk);
    #2;
    hold_en = 1'b1;
    done0   = done_pulses;
    pl.delete();
    for (int k = 0; k < 20; k++) pl.push_back(8'(8'hA0 + k));
    push_frame(0, 0);
    drive(0, acc);
    pl.delete();
    for (int k = 0; k < 50; k++) pl.push_back(8'(k));
    push_frame(0, 0);
    drive(0, acc);
    wait_idle(20000);
    check_eq("t5_gap", last_gap, 12);
    check_eq("t5_done_pulses", done_pulses - done0, 2);
    check_eq("t5_frame_cnt", frame_cnt, 5);
    check_eq("t5_hold", hold_viol, 0);
    hold_en = 1'b0;
    ce_div  = 1;
    repeat (12) @(posedge mac_tx_clk);
    #2;

    // Reset in the middle of DATA, then a clean frame.
    mon_en = 1'b0;
    rx_q.delete();
    s_data = 8'hAA; s_sof = 1'b1; s_valid = 1'b1;
    n = 0;
    while (rx_q.size() < 15 && n < 500) begin
      @(negedge mac_tx_clk);
      n++;
    end
    check_eq("t6_started", rx_q.size() >= 15, 1);
    @(negedge mac_tx_clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_tx_en", gmii_tx_en, 0);
    check_eq("t6_rst_txd", gmii_txd, 0);
    check_eq("t6_rst_tx_er", gmii_tx_er, 0);
    check_eq("t6_rst_frame_cnt", frame_cnt, 0);
    s_valid = 1'b0; s_sof = 1'b0;
    exp_q.delete();
    @(negedge mac_tx_clk);
    rst_n = 1'b1;
    @(posedge mac_tx_clk);
    #2;
    rx_q.delete();
    mon_en = 1'b1;
    pl.delete();
    for (int k = 0; k < 40; k++) pl.push_back(8'($urandom_range(0, 255)));
    push_frame(0, 0);
    drive(0, acc);
    wait_idle(2000);
    check_eq("t6_len", rx_q.size(), 72);
    check_eq("t6_residue", residue_of(8), 32'hC704DD7B);
    check_eq("t6_frame_cnt", frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
